// File: rtl/chan_seq_pkg.sv
// chan_seq_pkg: state encoding, ID width and one-hot helpers shared by chan_seq_ctrl and rr_pick
package chan_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, HOLD = 2'b10, REL = 2'b11} state_e;
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [63:0] onehot(input int unsigned i);
    return 64'(1) << i;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; req/ptr in, idx of first set req after ptr and vld out
module rr_pick import chan_seq_pkg::*; #(
  parameter int N_CH = 4,
  parameter int ID_W = id_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = N_CH; k >= 1; k--)
      if (req[(int'(ptr) + k) % N_CH]) begin
        idx = ID_W'((int'(ptr) + k) % N_CH);
        vld = 1'b1;
      end
  end
endmodule

// File: rtl/chan_seq_ctrl.sv
// chan_seq_ctrl: round-robin grant sequencer with hold timer and scan; CK/RN, req/done, SE/SI/SO, gnt/gnt_id/busy/timeout
module chan_seq_ctrl import chan_seq_pkg::*; #(
  parameter int N_CH     = 4,
  parameter int HOLD_W   = 4,
  parameter int MAX_HOLD = 8,
  localparam int ID_W    = id_w(N_CH)
) (
  input  logic            CK,
  input  logic            RN,
  input  logic [N_CH-1:0] req,
  input  logic            done,
  input  logic            SE,
  input  logic            SI,
  output logic            SO,
  output logic [N_CH-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);
  localparam int L = 3 + 2 * ID_W + HOLD_W;
  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, pick;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              to_q, to_d, vld;
  logic [L-1:0]      chain, chain_d;
  rr_pick #(.N_CH(N_CH), .ID_W(ID_W)) u_pick (.req(req), .ptr(ptr_q), .idx(pick), .vld(vld));
  assign chain = {state_q, ptr_q, id_q, cnt_q, to_q};
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    if (int'(id_q) >= N_CH) state_d = IDLE;
    else case (state_q)
      IDLE: if (vld) begin
        id_d    = pick;
        state_d = GRANT;
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: if (done) state_d = REL;
      else if (cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
        state_d = REL;
        to_d    = 1'b1;
      end
      else cnt_d = cnt_q + HOLD_W'(1);
      default: begin
        ptr_d   = id_q;
        to_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  assign chain_d = SE ? {SI, chain[L-1:1]} : {state_d, ptr_d, id_d, cnt_d, to_d};
  always_ff @(posedge CK or negedge RN)
    if (!RN) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(N_CH - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end
    else {state_q, ptr_q, id_q, cnt_q, to_q} <= chain_d;
  assign gnt     = (state_q == GRANT || state_q == HOLD) ? N_CH'(onehot(32'(id_q))) : '0;
  assign gnt_id  = id_q;
  assign busy    = state_q != IDLE;
  assign timeout = to_q;
  assign SO      = chain[0];
endmodule

// File: tb/tb_chan_seq_ctrl.sv
// tb_chan_seq_ctrl: scoreboard-driven bench for chan_seq_ctrl grants, hold limit, scan and reset
module tb_chan_seq_ctrl;
  localparam int L = 11;
  logic       CK = 0, RN = 0, done = 0, SE = 0, SI = 0;
  logic [3:0] req = '0;
  logic       SO, busy, timeout;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  int         errors = 0, checks = 0, cyc = 0;
  logic [3:0] exp_q[$];
  chan_seq_ctrl #(.N_CH(4), .HOLD_W(4), .MAX_HOLD(8)) dut (
    .CK(CK), .RN(RN), .req(req), .done(done), .SE(SE), .SI(SI), .SO(SO),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );
  always #5 CK = ~CK;
  task automatic step();
    @(posedge CK);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    RN = 0; req = '0; done = 0; SE = 0; SI = 0;
    step();
    RN = 1;
  endtask
  task automatic test_reset();
    logic [3:0] e;
    RN = 0; req = '0; done = 0; SE = 0; SI = 0;
    step();
    step();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got %0d want 0", gnt_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    checks++; if (SO !== 1'b0) begin errors++; $display("FAIL reset_so got %b want 0", SO); end
    RN = 1; req = 4'b0101; exp_q.push_back(4'b0001);
    step();
    e = exp_q.pop_front();
    checks++; if (gnt !== e) begin errors++; $display("FAIL first_gnt got %b want %b", gnt, e); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy); end
    step();
    done = 1;
    step();
    done = 0;
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rel_gnt got %b want 0000", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rel_busy got %b want 1", busy); end
    exp_q.push_back(4'b0100);
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    step();
    e = exp_q.pop_front();
    checks++; if (gnt !== e) begin errors++; $display("FAIL rr_second_gnt got %b want %b", gnt, e); end
    req = '0;
    step();
    done = 1;
    step();
    done = 0;
    step();
  endtask
  task automatic test_round_robin();
    logic [3:0] e;
    int last, n;
    do_reset();
    req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    last = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (gnt === 4'b0 && n < 10) begin
        step();
        n++;
      end
      e = exp_q.pop_front();
      checks++; if (gnt !== e) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", g, gnt, e); end
      if (g > 0) begin
        checks++; if (cyc - last !== 4) begin errors++; $display("FAIL rr_spacing[%0d] got %0d want 4", g, cyc - last); end
      end
      last = cyc;
      step();
      done = 1;
      step();
      done = 0;
    end
    req = '0;
    step();
  endtask
  task automatic test_timeout();
    logic [3:0] e;
    int n, t;
    do_reset();
    req = 4'b0100; exp_q.push_back(4'b0100);
    step();
    e = exp_q.pop_front();
    checks++; if (gnt !== e) begin errors++; $display("FAIL to_gnt got %b want %b", gnt, e); end
    req = '0;
    n = 0; t = 0;
    while (gnt === 4'b0100 && n < 20) begin
      n++;
      if (timeout) t++;
      step();
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL to_gnt_cycles got %0d want 9", n); end
    checks++; if (t !== 0) begin errors++; $display("FAIL to_early_pulse got %0d want 0", t); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", timeout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_rel_busy got %b want 1", busy); end
    step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got %b want 0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_end got %b want 0", busy); end
  endtask
  task automatic test_done_at_limit();
    logic [3:0] e;
    do_reset();
    req = 4'b0010; exp_q.push_back(4'b0010);
    step();
    e = exp_q.pop_front();
    checks++; if (gnt !== e) begin errors++; $display("FAIL lim_gnt got %b want %b", gnt, e); end
    req = '0;
    repeat (8) step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lim_hold_gnt got %b want 0010", gnt); end
    done = 1;
    step();
    done = 0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL lim_timeout got %b want 0", timeout); end
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL lim_rel_gnt got %b want 0000", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lim_rel_busy got %b want 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lim_idle_busy got %b want 0", busy); end
  endtask
  task automatic test_scan();
    logic [L-1:0] pat;
    logic [3:0] e;
    pat = {2'b10, 2'b01, 2'b11, 4'b0101, 1'b0};
    do_reset();
    SE = 1;
    for (int i = 0; i < L; i++) begin
      SI = pat[i];
      step();
    end
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL scan_gnt got %b want 1000", gnt); end
    checks++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL scan_gnt_id got %0d want 3", gnt_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy got %b want 1", busy); end
    for (int i = 0; i < L; i++) begin
      checks++; if (SO !== pat[i]) begin errors++; $display("FAIL scan_so[%0d] got %b want %b", i, SO, pat[i]); end
      SI = pat[i];
      step();
    end
    SE = 0; exp_q.push_back(4'b1000);
    e = exp_q.pop_front();
    checks++; if (gnt !== e) begin errors++; $display("FAIL scan_resume_gnt got %b want %b", gnt, e); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (timeout !== 1'b0 || gnt !== 4'b1000) begin errors++; $display("FAIL scan_hold[%0d] got to=%b gnt=%b want to=0 gnt=1000", i, timeout, gnt); end
    end
    step();
    checks++; if (timeout !== 1'b1 || gnt !== 4'b0) begin errors++; $display("FAIL scan_timeout got to=%b gnt=%b want to=1 gnt=0000", timeout, gnt); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_idle_busy got %b want 0", busy); end
  endtask
  task automatic test_async_reset();
    logic [3:0] e;
    do_reset();
    req = 4'b0100; exp_q.push_back(4'b0100);
    step();
    e = exp_q.pop_front();
    checks++; if (gnt !== e) begin errors++; $display("FAIL ar_pre_gnt got %b want %b", gnt, e); end
    req = '0;
    step();
    step();
    #3 RN = 0;
    #1;
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL ar_gnt got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy); end
    checks++; if (SO !== 1'b0) begin errors++; $display("FAIL ar_so got %b want 0", SO); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL ar_gnt_id got %0d want 0", gnt_id); end
    step();
    RN = 1; req = 4'b1111; exp_q.push_back(4'b0001);
    step();
    e = exp_q.pop_front();
    checks++; if (gnt !== e) begin errors++; $display("FAIL ar_first_gnt got %b want %b", gnt, e); end
    req = '0;
    step();
    done = 1;
    step();
    done = 0;
    step();
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_scan();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
